// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI host-interface receive path.
// Imported by the byte receiver and any downstream command/pixel logic.
package spi_pkg;

   typedef enum logic {SPI_IDLE, SPI_SHIFT} spi_state_t;

   localparam int   BYTE_W  = 8;
   localparam logic DC_CMD  = 1'b0;
   localparam logic DC_DATA = 1'b1;

endpackage

// File: rtl/spi_byte_rx.sv
// SPI slave byte receiver: assembles MOSI bits into bytes tagged with DC level,
// driven by pre-synchronized SCLK edge enables and chip-select level.
module spi_byte_rx
   import spi_pkg::*;
#(
   parameter bit CPHA      = 1'b0,
   parameter bit MSB_FIRST = 1'b1,
   parameter int IDX_W     = 10
) (
   input  logic              clk_in,
   input  logic              rst_n_in,
   input  logic              spi_sclk_rising_in,
   input  logic              spi_sclk_falling_in,
   input  logic              spi_cs_n_in,
   input  logic              spi_mosi_in,
   input  logic              spi_dc_in,
   output logic              byte_rdy_out,
   output logic [BYTE_W-1:0] byte_data_out,
   output logic              byte_is_data_out,
   output logic [IDX_W-1:0]  byte_idx_out,
   output logic              frame_start_out,
   output logic              frame_abort_out
);

   localparam logic [IDX_W-1:0] IDX_MAX = '1;

   spi_state_t        state_q, state_d;
   logic [2:0]        bit_cnt_q, bit_cnt_d;
   logic [BYTE_W-1:0] shift_q, shift_d;
   logic [IDX_W-1:0]  byte_cnt_q, byte_cnt_d;
   logic              byte_rdy_q, byte_rdy_d;
   logic [BYTE_W-1:0] byte_data_q, byte_data_d;
   logic              byte_is_data_q, byte_is_data_d;
   logic [IDX_W-1:0]  byte_idx_q, byte_idx_d;
   logic              frame_start_q, frame_start_d;
   logic              frame_abort_q, frame_abort_d;

   logic              sample_en;
   logic [BYTE_W-1:0] shifted;

   // A sampling edge that coincides with CS rising is gated off here.
   assign sample_en = (CPHA ? spi_sclk_falling_in : spi_sclk_rising_in) & ~spi_cs_n_in;
   assign shifted   = MSB_FIRST ? {shift_q[BYTE_W-2:0], spi_mosi_in}
                                : {spi_mosi_in, shift_q[BYTE_W-1:1]};

   always_comb begin
      state_d        = state_q;
      bit_cnt_d      = bit_cnt_q;
      shift_d        = shift_q;
      byte_cnt_d     = byte_cnt_q;
      byte_rdy_d     = 1'b0;
      byte_data_d    = byte_data_q;
      byte_is_data_d = byte_is_data_q;
      byte_idx_d     = byte_idx_q;
      frame_start_d  = 1'b0;
      frame_abort_d  = 1'b0;

      case (state_q)
         SPI_IDLE: begin
            if (!spi_cs_n_in) begin
               state_d       = SPI_SHIFT;
               frame_start_d = 1'b1;
               byte_cnt_d    = '0;
               // An edge arriving together with the CS fall is the frame's first bit.
               if (sample_en) begin
                  shift_d   = shifted;
                  bit_cnt_d = 3'd1;
               end else begin
                  bit_cnt_d = 3'd0;
               end
            end
         end
         SPI_SHIFT: begin
            if (spi_cs_n_in) begin
               state_d       = SPI_IDLE;
               frame_abort_d = (bit_cnt_q != 3'd0);
               bit_cnt_d     = 3'd0;
               shift_d       = '0;
            end else if (sample_en) begin
               shift_d   = shifted;
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  byte_rdy_d     = 1'b1;
                  byte_data_d    = shifted;
                  byte_is_data_d = (spi_dc_in == DC_DATA);
                  byte_idx_d     = byte_cnt_q;
                  if (byte_cnt_q != IDX_MAX) begin
                     byte_cnt_d = byte_cnt_q + 1'b1;
                  end
               end
            end
         end
         default: state_d = SPI_IDLE;
      endcase
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q        <= SPI_IDLE;
         bit_cnt_q      <= 3'd0;
         shift_q        <= '0;
         byte_cnt_q     <= '0;
         byte_rdy_q     <= 1'b0;
         byte_data_q    <= '0;
         byte_is_data_q <= DC_CMD;
         byte_idx_q     <= '0;
         frame_start_q  <= 1'b0;
         frame_abort_q  <= 1'b0;
      end else begin
         state_q        <= state_d;
         bit_cnt_q      <= bit_cnt_d;
         shift_q        <= shift_d;
         byte_cnt_q     <= byte_cnt_d;
         byte_rdy_q     <= byte_rdy_d;
         byte_data_q    <= byte_data_d;
         byte_is_data_q <= byte_is_data_d;
         byte_idx_q     <= byte_idx_d;
         frame_start_q  <= frame_start_d;
         frame_abort_q  <= frame_abort_d;
      end
   end

   assign byte_rdy_out     = byte_rdy_q;
   assign byte_data_out    = byte_data_q;
   assign byte_is_data_out = byte_is_data_q;
   assign byte_idx_out     = byte_idx_q;
   assign frame_start_out  = frame_start_q;
   assign frame_abort_out  = frame_abort_q;

endmodule

// File: tb/tb_spi_byte_rx.sv
// Scoreboard bench for spi_byte_rx: three configurations share one stimulus stream,
// a bit-list reference model queues expected events, a monitor retires them.
`timescale 1ns/1ps
module tb_spi_byte_rx;

   localparam int NI = 3;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic cs_n = 1'b1, rise = 1'b0, fall = 1'b0, mosi = 1'b0, dc = 1'b0;

   logic       rdy_o [NI];
   logic [7:0] data_o[NI];
   logic       isd_o [NI];
   logic       fs_o  [NI];
   logic       fa_o  [NI];
   logic [9:0] idx_a, idx_c;
   logic [1:0] idx_b;

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   spi_byte_rx #(.CPHA(1'b0), .MSB_FIRST(1'b1), .IDX_W(10)) u_a (
      .clk_in(clk), .rst_n_in(rst_n),
      .spi_sclk_rising_in(rise), .spi_sclk_falling_in(fall),
      .spi_cs_n_in(cs_n), .spi_mosi_in(mosi), .spi_dc_in(dc),
      .byte_rdy_out(rdy_o[0]), .byte_data_out(data_o[0]), .byte_is_data_out(isd_o[0]),
      .byte_idx_out(idx_a), .frame_start_out(fs_o[0]), .frame_abort_out(fa_o[0]));

   spi_byte_rx #(.CPHA(1'b0), .MSB_FIRST(1'b0), .IDX_W(2)) u_b (
      .clk_in(clk), .rst_n_in(rst_n),
      .spi_sclk_rising_in(rise), .spi_sclk_falling_in(fall),
      .spi_cs_n_in(cs_n), .spi_mosi_in(mosi), .spi_dc_in(dc),
      .byte_rdy_out(rdy_o[1]), .byte_data_out(data_o[1]), .byte_is_data_out(isd_o[1]),
      .byte_idx_out(idx_b), .frame_start_out(fs_o[1]), .frame_abort_out(fa_o[1]));

   spi_byte_rx #(.CPHA(1'b1), .MSB_FIRST(1'b1), .IDX_W(10)) u_c (
      .clk_in(clk), .rst_n_in(rst_n),
      .spi_sclk_rising_in(rise), .spi_sclk_falling_in(fall),
      .spi_cs_n_in(cs_n), .spi_mosi_in(mosi), .spi_dc_in(dc),
      .byte_rdy_out(rdy_o[2]), .byte_data_out(data_o[2]), .byte_is_data_out(isd_o[2]),
      .byte_idx_out(idx_c), .frame_start_out(fs_o[2]), .frame_abort_out(fa_o[2]));

   function automatic bit cfg_cpha(input int k);
      return (k == 2);
   endfunction
   function automatic bit cfg_msb(input int k);
      return (k != 1);
   endfunction
   function automatic int cfg_idx_max(input int k);
      return (k == 1) ? 3 : 1023;
   endfunction
   function automatic int get_idx(input int k);
      if (k == 0) return int'(idx_a);
      if (k == 1) return int'(idx_b);
      return int'(idx_c);
   endfunction

   localparam int EV_START = 0, EV_BYTE = 1, EV_ABORT = 2;
   typedef struct {
      int       inst;
      int       kind;
      int       data;
      int       dcv;
      int       idx;
      int       cyc;
   } ev_t;
   ev_t evq[$];

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input int k, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s inst%0d cyc%0d: got %0h want %0h", nm, k, cyc, act, exp);
      end
   endtask

   // Reference model: frames are lists of sampled bits; a byte is the weighted sum of 8 bits.
   bit in_frame[NI];
   int nbits   [NI];
   bit bitbuf  [NI][8];
   int mdl_idx [NI];

   function automatic void push_ev(input int k, input int kind, input int d, input int dv,
                                   input int ix, input int c);
      ev_t e;
      e.inst = k; e.kind = kind; e.data = d; e.dcv = dv; e.idx = ix; e.cyc = c;
      evq.push_back(e);
   endfunction

   function automatic void model_step(input bit c_n, input bit r, input bit f, input bit m,
                                      input bit d, input int cur);
      bit samp;
      int val;
      for (int k = 0; k < NI; k++) begin
         samp = (cfg_cpha(k) ? f : r) && !c_n;
         if (!in_frame[k]) begin
            if (!c_n) begin
               in_frame[k] = 1'b1;
               nbits[k]    = 0;
               mdl_idx[k]  = 0;
               push_ev(k, EV_START, 0, 0, 0, cur + 1);
               if (samp) begin
                  bitbuf[k][0] = m;
                  nbits[k]     = 1;
               end
            end
         end else if (c_n) begin
            if (nbits[k] != 0) push_ev(k, EV_ABORT, 0, 0, 0, cur + 1);
            in_frame[k] = 1'b0;
            nbits[k]    = 0;
         end else if (samp) begin
            bitbuf[k][nbits[k]] = m;
            nbits[k]++;
            if (nbits[k] == 8) begin
               val = 0;
               for (int i = 0; i < 8; i++)
                  val += int'(bitbuf[k][i]) * (1 << (cfg_msb(k) ? 7 - i : i));
               push_ev(k, EV_BYTE, val, int'(d), mdl_idx[k], cur + 1);
               if (mdl_idx[k] < cfg_idx_max(k)) mdl_idx[k]++;
               nbits[k] = 0;
            end
         end
      end
   endfunction

   // Monitor: retire one expected event per observed pulse, check held outputs every cycle.
   int held_data[NI];
   int held_dc  [NI];
   int held_idx [NI];

   function automatic int find_ev(input int k, input int kind);
      int hits[$];
      hits = evq.find_first_index(e) with (e.inst == k && e.kind == kind);
      return (hits.size() == 0) ? -1 : hits[0];
   endfunction

   always @(negedge clk) begin
      int j;
      for (int k = 0; k < NI; k++) begin
         if (!rst_n) begin
            held_data[k] = 0; held_dc[k] = 0; held_idx[k] = 0;
            chk("rst_rdy", k, rdy_o[k], 0);
            chk("rst_start", k, fs_o[k], 0);
            chk("rst_abort", k, fa_o[k], 0);
            chk("rst_data", k, data_o[k], 0);
            chk("rst_isdata", k, isd_o[k], 0);
            chk("rst_idx", k, get_idx(k), 0);
            continue;
         end
         if (fs_o[k]) begin
            j = find_ev(k, EV_START);
            if (j < 0) chk("unexp_start", k, fs_o[k], 0);
            else begin
               chk("start_cycle", k, cyc, evq[j].cyc);
               evq.delete(j);
            end
         end
         if (fa_o[k]) begin
            j = find_ev(k, EV_ABORT);
            if (j < 0) chk("unexp_abort", k, fa_o[k], 0);
            else begin
               chk("abort_cycle", k, cyc, evq[j].cyc);
               evq.delete(j);
            end
         end
         if (rdy_o[k]) begin
            j = find_ev(k, EV_BYTE);
            if (j < 0) chk("unexp_rdy", k, rdy_o[k], 0);
            else begin
               chk("rdy_cycle", k, cyc, evq[j].cyc);
               held_data[k] = evq[j].data;
               held_dc[k]   = evq[j].dcv;
               held_idx[k]  = evq[j].idx;
               $display("byte inst%0d cyc%0d data=%02h is_data=%0d idx=%0d", k, cyc,
                        data_o[k], isd_o[k], get_idx(k));
               evq.delete(j);
            end
         end
         chk("data", k, data_o[k], held_data[k]);
         chk("is_data", k, isd_o[k], held_dc[k]);
         chk("idx", k, get_idx(k), held_idx[k]);
         for (int i = evq.size() - 1; i >= 0; i--) begin
            if (evq[i].inst == k && evq[i].cyc <= cyc) begin
               total++;
               bad++;
               $display("FAIL missing_event inst%0d kind%0d: got none want pulse at cyc%0d",
                        k, evq[i].kind, evq[i].cyc);
               evq.delete(i);
            end
         end
      end
   end

   // Stimulus: every tick drives exactly one clock cycle of inputs.
   task automatic tick(input bit c_n, input bit r, input bit f, input bit m, input bit d);
      @(posedge clk);
      #1;
      cs_n = c_n; rise = r; fall = f; mosi = m; dc = d;
      model_step(c_n, r, f, m, d, cyc);
   endtask

   task automatic send_bit(input bit b, input bit d);
      int gap;
      tick(1'b0, 1'b1, 1'b0, b, d);
      tick(1'b0, 1'b0, 1'b1, b, d);
      gap = $urandom_range(0, 2);
      for (int i = 0; i < gap; i++) tick(1'b0, 1'b0, 1'b0, b, d);
   endtask

   task automatic send_byte(input logic [7:0] v, input bit d);
      for (int i = 7; i >= 0; i--) send_bit(v[i], d);
   endtask

   task automatic cs_down();
      tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic cs_up();
      tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic reset_mid();
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      cs_n = 1'b1; rise = 1'b0; fall = 1'b0;
      #1;
      for (int k = 0; k < NI; k++) begin
         chk("async_rst_data", k, data_o[k], 0);
         chk("async_rst_rdy", k, rdy_o[k], 0);
         chk("async_rst_idx", k, get_idx(k), 0);
      end
      evq.delete();
      for (int k = 0; k < NI; k++) begin
         in_frame[k] = 1'b0;
         nbits[k]    = 0;
      end
      repeat (2) @(posedge clk);
      #3;
      rst_n = 1'b1;
   endtask

   initial begin
      logic [7:0] v;
      int nb;
      repeat (3) @(posedge clk);
      #3;
      rst_n = 1'b1;

      // Single byte 0xA5 (bit-palindrome, so every configuration expects 0xA5)
      cs_down(); send_byte(8'hA5, 1'b1); cs_up();
      cs_down(); send_byte(8'hA5, 1'b0); cs_up();

      // Back-to-back bytes, then a new frame restarts the index
      cs_down();
      send_byte(8'h2A, 1'b1); send_byte(8'h00, 1'b0); send_byte(8'hFF, 1'b1);
      cs_up();
      cs_down(); send_byte(8'h81, 1'b1); cs_up();

      // Partial byte then CS high, then a clean frame
      cs_down();
      for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b1);
      cs_up();
      cs_down(); send_byte(8'h5E, 1'b1); cs_up();

      // CS rises together with the 8th sampling edge
      cs_down();
      for (int i = 0; i < 7; i++) send_bit(i[0], 1'b1);
      tick(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
      cs_up();

      // Sampling edge coincides with the CS fall
      v = 8'hC3;
      tick(1'b0, 1'b1, 1'b0, v[7], 1'b0);
      tick(1'b0, 1'b0, 1'b1, v[7], 1'b0);
      for (int i = 6; i >= 0; i--) send_bit(v[i], 1'b0);
      cs_up();

      // Asynchronous reset mid-byte, then recovery
      cs_down();
      for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b1);
      reset_mid();
      cs_up();
      cs_down(); send_byte(8'h3C, 1'b1); cs_up();

      // Index saturation with the 2-bit counter
      cs_down();
      for (int i = 0; i < 5; i++) send_byte(8'(8'h10 + i), 1'b1);
      cs_up();

      // Randomized frames, some ending in a partial byte
      for (int f = 0; f < 30; f++) begin
         cs_down();
         nb = $urandom_range(1, 4);
         for (int b = 0; b < nb; b++) send_byte(8'($urandom), 1'($urandom));
         if ($urandom_range(0, 3) == 0) begin
            nb = $urandom_range(1, 7);
            for (int i = 0; i < nb; i++) send_bit(1'($urandom), 1'($urandom));
         end
         cs_up();
      end

      repeat (5) tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      chk("leftover_events", -1, evq.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
